// File: rtl/host_loader_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | host_loader_pkg                                                            |
// | Shared word/address widths and the loader state encoding.                  |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
package host_loader_pkg;

  localparam int c_data_w = 16;
  localparam int c_addr_w = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_PROG = 3'd1,
    ST_LOAD_IN   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RD_ADDR   = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_SEND      = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/host_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | host_loader_if                                                             |
// | Host input/result streams plus the main-memory port of the loader.         |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface host_loader_if #(
  parameter int DATA_W = host_loader_pkg::c_data_w,
  parameter int ADDR_W = host_loader_pkg::c_addr_w
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  in_valid, in_data, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/host_loader_ctr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | host_loader_ctr                                                            |
// | Up-counter with synchronous clear, enable and a terminal-value flag.       |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
module host_loader_ctr #(
  parameter int W = 16
) (
  input  wire          clk,
  input  wire          rst_n,
  input  wire          clr,
  input  wire          en,
  input  wire  [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign term = (r_cnt == last);

endmodule
`default_nettype wire

// File: rtl/host_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | host_loader                                                                |
// | Loads program/operands into main memory, runs the CPU, streams results.    |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
module host_loader
  import host_loader_pkg::*;
#(
  parameter int DATA_W     = c_data_w,
  parameter int ADDR_W     = c_addr_w,
  parameter int IN_BASE    = 100,
  parameter int N_IN       = 3,
  parameter int OUT_BASE   = 103,
  parameter int N_OUT      = 1,
  parameter int MAX_CYCLES = 1000
) (
  input  wire           clk,
  input  wire           rst_n,
  host_loader_if.master bus,
  output logic          cpu_rst,
  input  wire           cpu_halt,
  output logic          busy,
  output logic          timeout,
  output logic          err
);

  localparam int                c_cyc_w    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(MAX_CYCLES - 1);
  localparam logic [DATA_W-1:0]  c_in_last  = DATA_W'(N_IN - 1);
  localparam logic [DATA_W-1:0]  c_out_last = DATA_W'(N_OUT - 1);
  localparam logic [DATA_W-1:0]  c_in_lim   = DATA_W'(IN_BASE);
  localparam logic [ADDR_W-1:0]  c_in_addr  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0]  c_out_addr = ADDR_W'(OUT_BASE);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_in_acc;
  logic                w_out_acc;
  logic                w_run_done;
  logic                w_idx_clr;
  logic                w_idx_en;
  logic                w_idx_term;
  logic [DATA_W-1:0]   w_idx;
  logic [DATA_W-1:0]   w_idx_last;
  logic                w_cyc_clr;
  logic                w_cyc_en;
  logic                w_cyc_term;
  logic [c_cyc_w-1:0]  w_cyc_cnt;
  logic                w_unused_cyc;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   r_len;
  logic                r_timeout;
  logic                r_err;

  assign w_in_acc     = bus.in_valid & w_in_ready;
  assign w_out_acc    = w_out_valid & bus.out_ready;
  assign w_run_done   = cpu_halt | w_cyc_term;
  assign w_unused_cyc = ^w_cyc_cnt;

  // One index counter serves program word k, operand j and result i in turn.
  assign w_idx_last = (r_state == ST_LOAD_PROG) ? (r_len - DATA_W'(1)) :
                      (r_state == ST_LOAD_IN)   ? c_in_last : c_out_last;

  host_loader_ctr #(.W(DATA_W)) u_idx_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_idx_clr),
    .en    (w_idx_en),
    .last  (w_idx_last),
    .cnt   (w_idx),
    .term  (w_idx_term)
  );

  host_loader_ctr #(.W(c_cyc_w)) u_cyc_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cyc_clr),
    .en    (w_cyc_en),
    .last  (c_cyc_last),
    .cnt   (w_cyc_cnt),
    .term  (w_cyc_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_acc) begin
          w_state_nxt = (bus.in_data == '0) ? ST_LOAD_IN : ST_LOAD_PROG;
        end
      end
      ST_LOAD_PROG: if (w_in_acc && w_idx_term) w_state_nxt = ST_LOAD_IN;
      ST_LOAD_IN:   if (w_in_acc && w_idx_term) w_state_nxt = ST_RUN;
      ST_RUN:       if (w_run_done) w_state_nxt = ST_RD_ADDR;
      ST_RD_ADDR:   w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:   w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_out_acc) begin
          w_state_nxt = w_idx_term ? ST_IDLE : ST_RD_ADDR;
        end
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    busy        = 1'b1;
    cpu_rst     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = rst_n;
        busy       = 1'b0;
      end
      ST_LOAD_PROG, ST_LOAD_IN: w_in_ready  = rst_n;
      ST_RUN:                   cpu_rst     = 1'b0;
      ST_SEND:                  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_idx_clr = 1'b0;
    w_idx_en  = 1'b0;
    w_cyc_clr = (r_state != ST_RUN);
    w_cyc_en  = (r_state == ST_RUN);
    case (r_state)
      ST_IDLE, ST_RUN: w_idx_clr = 1'b1;
      ST_LOAD_PROG, ST_LOAD_IN: begin
        w_idx_clr = w_in_acc & w_idx_term;
        w_idx_en  = w_in_acc & ~w_idx_term;
      end
      ST_SEND: begin
        w_idx_clr = w_out_acc & w_idx_term;
        w_idx_en  = w_out_acc & ~w_idx_term;
      end
      default: ;
    endcase
  end

  // mem_addr is loaded one state early so RD_ADDR presents OUT_BASE+i directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_out_data  <= '0;
      r_len       <= '0;
      r_timeout   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_acc) begin
            r_len     <= bus.in_data;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        ST_LOAD_PROG: begin
          if (w_in_acc) begin
            if (w_idx < c_in_lim) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= ADDR_W'(w_idx);
              r_mem_wdata <= bus.in_data;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD_IN: begin
          if (w_in_acc) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= c_in_addr + ADDR_W'(w_idx);
            r_mem_wdata <= bus.in_data;
          end
        end
        ST_RUN: begin
          if (w_cyc_term && !cpu_halt) begin
            r_timeout <= 1'b1;
          end
          if (w_run_done) begin
            r_mem_addr <= c_out_addr;
          end
        end
        ST_RD_WAIT: r_out_data <= bus.mem_rdata;
        ST_SEND: begin
          if (w_out_acc && !w_idx_term) begin
            r_mem_addr <= c_out_addr + ADDR_W'(w_idx) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign timeout       = r_timeout;
  assign err           = r_err;

endmodule
`default_nettype wire
